// File: rtl/ps2_cmd_pkg.sv
`default_nettype none
// =============================================================================
// Module   : ps2_cmd_pkg
// Brief    : Shared types, ASCII constants and opcode decode for ps2_cmd_parser.
// Config   : PS2_CMD_LOWERCASE_EN - accept v/a/f as opcodes
// Revision : 1.0 - initial release
// =============================================================================
package ps2_cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PARSE  = 2'd1,
      ST_COMMIT = 2'd2,
      ST_CLEAR  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_VEL  = 2'd1,
      OP_ANG  = 2'd2,
      OP_FIRE = 2'd3
   } opcode_t;

   localparam logic [7:0] c_ascii_bs       = 8'h08;
   localparam logic [7:0] c_ascii_cr       = 8'h0D;
   localparam logic [7:0] c_ascii_lf       = 8'h0A;
   localparam logic [7:0] c_ascii_v        = 8'h56;
   localparam logic [7:0] c_ascii_a        = 8'h41;
   localparam logic [7:0] c_ascii_f        = 8'h46;
   localparam logic [7:0] c_ascii_0        = 8'h30;
   localparam logic [7:0] c_ascii_9        = 8'h39;
   localparam logic [7:0] c_ascii_print_lo = 8'h20;
   localparam logic [7:0] c_ascii_print_hi = 8'h7E;

   function automatic opcode_t decode_opcode(input logic [7:0] ch);
      logic [7:0] up;
      opcode_t    op;
      up = ch;
`ifdef PS2_CMD_LOWERCASE_EN
      // Fold only the three opcode letters; other lowercase stays unknown.
      if (ch == 8'h76 || ch == 8'h61 || ch == 8'h66) up = ch & 8'hDF;
`endif
      case (up)
         c_ascii_v: op = OP_VEL;
         c_ascii_a: op = OP_ANG;
         c_ascii_f: op = OP_FIRE;
         default:   op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_dec_accum.sv
`default_nettype none
// =============================================================================
// Module   : ps2_dec_accum
// Brief    : 16-bit decimal accumulator (acc*10+digit), saturating, sticky overflow.
// Revision : 1.0 - initial release
// =============================================================================
module ps2_dec_accum (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_clear,
   input  logic        i_step,
   input  logic [3:0]  i_digit,
   output logic [15:0] o_value,
   output logic        o_overflow
);

   logic [15:0] value_q, value_d;
   logic        ovf_q, ovf_d;
   logic [19:0] w_next;

   always_comb begin
      w_next  = 20'(value_q) * 20'd10 + 20'(i_digit);
      value_d = value_q;
      ovf_d   = ovf_q;
      if (i_clear) begin
         value_d = '0;
         ovf_d   = 1'b0;
      end else if (i_step) begin
         if (ovf_q || (w_next > 20'h0FFFF)) begin
            value_d = 16'hFFFF;
            ovf_d   = 1'b1;
         end else begin
            value_d = w_next[15:0];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         value_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         value_q <= value_d;
         ovf_q   <= ovf_d;
      end
   end

   assign o_value    = value_q;
   assign o_overflow = ovf_q;

endmodule
`default_nettype wire

// File: rtl/ps2_cmd_parser.sv
`default_nettype none
// =============================================================================
// Module   : ps2_cmd_parser
// Brief    : Line editor + V<n>/A<n>/F command decoder driving velocity/angle/fire.
// Config   : PS2_CMD_LOWERCASE_EN - lowercase opcodes accepted (default: rejected)
// Revision : 1.0 - initial release
// =============================================================================
module ps2_cmd_parser
   import ps2_cmd_pkg::*;
#(
   parameter int LINE_CHARS  = 32,
   parameter int VEL_MAX     = 100,
   parameter int ANGLE_MAX   = 90,
   parameter int FIRE_CYCLES = 50_000_000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [7:0]              input_character,
   input  logic                    input_made,
   output logic [8*LINE_CHARS-1:0] line_content,
   output logic                    line_ready,
   output logic [31:0]             velocity,
   output logic [31:0]             angle,
   output logic                    fire,
   output logic                    cmd_error,
   output logic                    busy
);

   localparam int LEN_W = $clog2(LINE_CHARS + 1);
   localparam int FC_W  = (FIRE_CYCLES > 1) ? $clog2(FIRE_CYCLES + 1) : 1;

   localparam logic [LEN_W-1:0] c_len_full  = LEN_W'(LINE_CHARS);
   localparam logic [FC_W-1:0]  c_fire_load = FC_W'(FIRE_CYCLES);
   localparam logic [15:0]      c_vel_max   = 16'(VEL_MAX);
   localparam logic [15:0]      c_ang_max   = 16'(ANGLE_MAX);

   state_t                      state_q, state_d;
   logic [LINE_CHARS-1:0][7:0]  line_q, line_d;
   logic [LEN_W-1:0]            len_q, len_d;
   logic [LEN_W-1:0]            idx_q, idx_d;
   opcode_t                     op_q, op_d;
   logic                        perr_q, perr_d;
   logic                        digit_seen_q, digit_seen_d;
   logic [15:0]                 velocity_q, velocity_d;
   logic [15:0]                 angle_q, angle_d;
   logic                        cmd_error_q, cmd_error_d;
   logic                        line_ready_q, line_ready_d;
   logic [FC_W-1:0]             fire_cnt_q, fire_cnt_d;

   logic [7:0]  w_char;
   logic        w_is_digit;
   logic        w_key_print;
   logic        w_key_bs;
   logic        w_key_enter;
   logic        w_acc_clear;
   logic        w_acc_step;
   logic [15:0] w_acc_value;
   logic        w_acc_ovf;
   logic        w_line_ok;

   ps2_dec_accum u_accum (
      .clock      (clock),
      .reset      (reset),
      .i_clear    (w_acc_clear),
      .i_step     (w_acc_step),
      .i_digit    (w_char[3:0]),
      .o_value    (w_acc_value),
      .o_overflow (w_acc_ovf)
   );

   always_comb begin
      w_char = '0;
      for (int i = 0; i < LINE_CHARS; i++) begin
         if (LEN_W'(i) == idx_q) w_char = line_q[i];
      end
   end

   assign w_is_digit  = (w_char >= c_ascii_0) && (w_char <= c_ascii_9);
   assign w_key_print = (input_character >= c_ascii_print_lo) && (input_character <= c_ascii_print_hi);
   assign w_key_bs    = (input_character == c_ascii_bs);
   assign w_key_enter = (input_character == c_ascii_cr) || (input_character == c_ascii_lf);
   assign w_acc_clear = (state_q == ST_IDLE);
   assign w_acc_step  = (state_q == ST_PARSE) && (idx_q != '0) && w_is_digit;

   assign w_line_ok = !perr_q &&
                      ((op_q == OP_FIRE) ||
                       (digit_seen_q && !w_acc_ovf &&
                        (((op_q == OP_VEL) && (w_acc_value <= c_vel_max)) ||
                         ((op_q == OP_ANG) && (w_acc_value <= c_ang_max)))));

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (input_made && w_key_enter) state_d = (len_q != '0) ? ST_PARSE : ST_COMMIT;
         end
         ST_PARSE: begin
            if (idx_q == len_q - LEN_W'(1)) state_d = ST_COMMIT;
         end
         ST_COMMIT: state_d = ST_CLEAR;
         ST_CLEAR:  state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_q != ST_IDLE);
   end

   always_comb begin
      line_d       = line_q;
      len_d        = len_q;
      idx_d        = idx_q;
      op_d         = op_q;
      perr_d       = perr_q;
      digit_seen_d = digit_seen_q;
      velocity_d   = velocity_q;
      angle_d      = angle_q;
      cmd_error_d  = cmd_error_q;
      line_ready_d = line_ready_q;
      fire_cnt_d   = (fire_cnt_q != '0) ? fire_cnt_q - FC_W'(1) : '0;

      case (state_q)
         ST_IDLE: begin
            idx_d        = '0;
            op_d         = OP_NONE;
            perr_d       = 1'b0;
            digit_seen_d = 1'b0;
            if (input_made) begin
               if (w_key_print && (len_q != c_len_full)) begin
                  for (int i = 0; i < LINE_CHARS; i++) begin
                     if (LEN_W'(i) == len_q) line_d[i] = input_character;
                  end
                  len_d = len_q + LEN_W'(1);
               end else if (w_key_bs && (len_q != '0)) begin
                  for (int i = 0; i < LINE_CHARS; i++) begin
                     if (LEN_W'(i) == len_q - LEN_W'(1)) line_d[i] = '0;
                  end
                  len_d = len_q - LEN_W'(1);
               end
            end
         end

         ST_PARSE: begin
            idx_d = idx_q + LEN_W'(1);
            if (idx_q == '0) begin
               op_d = decode_opcode(w_char);
               if (op_d == OP_NONE) perr_d = 1'b1;
            end else if ((op_q == OP_FIRE) || !w_is_digit) begin
               perr_d = 1'b1;
            end else begin
               digit_seen_d = 1'b1;
            end
         end

         ST_COMMIT: begin
            line_ready_d = 1'b1;
            if (len_q == '0) begin
               cmd_error_d = 1'b0;
            end else if (w_line_ok) begin
               cmd_error_d = 1'b0;
               case (op_q)
                  OP_VEL:  velocity_d = w_acc_value;
                  OP_ANG:  angle_d    = w_acc_value;
                  OP_FIRE: fire_cnt_d = c_fire_load;
                  default: ;
               endcase
            end else begin
               cmd_error_d = 1'b1;
            end
         end

         ST_CLEAR: begin
            line_d       = '0;
            len_d        = '0;
            line_ready_d = 1'b0;
         end

         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         line_q       <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         op_q         <= OP_NONE;
         perr_q       <= 1'b0;
         digit_seen_q <= 1'b0;
         velocity_q   <= '0;
         angle_q      <= '0;
         cmd_error_q  <= 1'b0;
         line_ready_q <= 1'b0;
         fire_cnt_q   <= '0;
      end else begin
         line_q       <= line_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         op_q         <= op_d;
         perr_q       <= perr_d;
         digit_seen_q <= digit_seen_d;
         velocity_q   <= velocity_d;
         angle_q      <= angle_d;
         cmd_error_q  <= cmd_error_d;
         line_ready_q <= line_ready_d;
         fire_cnt_q   <= fire_cnt_d;
      end
   end

   assign line_content = line_q;
   assign line_ready   = line_ready_q;
   assign velocity     = {16'd0, velocity_q};
   assign angle        = {16'd0, angle_q};
   assign fire         = (fire_cnt_q != '0);
   assign cmd_error    = cmd_error_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_cmd_parser.sv
`default_nettype none
// =============================================================================
// Module   : tb_ps2_cmd_parser
// Brief    : Scoreboard bench for ps2_cmd_parser with a string-level line/command model.
// Config   : PS2_CMD_LOWERCASE_EN - must match the RTL build
// Revision : 1.0 - initial release
// =============================================================================
module tb_ps2_cmd_parser;

   localparam int LC = 32;
   localparam int FC = 10;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    input_character = 8'h00;
   logic          input_made = 1'b0;
   logic [8*LC-1:0] line_content;
   logic          line_ready;
   logic [31:0]   velocity;
   logic [31:0]   angle;
   logic          fire;
   logic          cmd_error;
   logic          busy;

   ps2_cmd_parser #(
      .LINE_CHARS  (LC),
      .VEL_MAX     (100),
      .ANGLE_MAX   (90),
      .FIRE_CYCLES (FC)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .input_character (input_character),
      .input_made      (input_made),
      .line_content    (line_content),
      .line_ready      (line_ready),
      .velocity        (velocity),
      .angle           (angle),
      .fire            (fire),
      .cmd_error       (cmd_error),
      .busy            (busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [8*LC-1:0] line;
      logic [31:0]     vel;
      logic [31:0]     ang;
      logic            err;
      bit              fire;
      int              commit;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] line_m[$];
   logic [31:0] vel_m = 0;
   logic [31:0] ang_m = 0;
   logic        err_m = 0;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops an expectation for every line_ready strobe and tracks the fire window.
   exp_t mon_e;
   int   fire_end = 0;
   bit   chk_after = 0;
   always @(negedge clock) begin
      if (reset) begin
         sb.delete();
         fire_end  = 0;
         chk_after = 0;
      end else begin
         if (chk_after) begin
            check("line_cleared", line_content, '0);
            check("busy_after_line", busy, 0);
            chk_after = 0;
         end
         if (line_ready) begin
            if (sb.size() == 0) begin
               check("line_ready_unexpected", line_ready, 0);
            end else begin
               mon_e = sb.pop_front();
               check("commit_edge", cyc, mon_e.commit);
               check("line_content", line_content, mon_e.line);
               check("velocity", velocity, mon_e.vel);
               check("angle", angle, mon_e.ang);
               check("cmd_error", cmd_error, mon_e.err);
               check("busy_during_ready", busy, 1);
               if (mon_e.fire) fire_end = mon_e.commit + FC;
               chk_after = 1;
            end
         end
         check("fire", fire, (cyc < fire_end));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [7:0] c);
      input_character = c;
      input_made      = 1'b1;
      tick();
      input_made      = 1'b0;
      if (c >= 8'h20 && c <= 8'h7E) begin
         if (line_m.size() < LC) line_m.push_back(c);
      end else if (c == 8'h08) begin
         if (line_m.size() > 0) void'(line_m.pop_back());
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic model_commit(output exp_t ex);
      int         n;
      logic [7:0] op;
      bit         ok;
      bit         ovf;
      longint     v;
      n       = line_m.size();
      ex.line = '0;
      for (int i = 0; i < n; i++) ex.line[8*i +: 8] = line_m[i];
      ex.fire = 0;
      if (n == 0) begin
         err_m = 0;
      end else begin
         op = line_m[0];
`ifdef PS2_CMD_LOWERCASE_EN
         if (op == 8'h76 || op == 8'h61 || op == 8'h66) op = op - 8'h20;
`endif
         ok  = 0;
         ovf = 0;
         v   = 0;
         if (op == 8'h46) begin
            ok = (n == 1);
         end else if (op == 8'h56 || op == 8'h41) begin
            ok = (n > 1);
            for (int i = 1; i < n; i++) begin
               if (line_m[i] >= 8'h30 && line_m[i] <= 8'h39) begin
                  if (!ovf) begin
                     v = v * 10 + longint'(line_m[i] - 8'h30);
                     if (v > 65535) ovf = 1;
                  end
               end else begin
                  ok = 0;
               end
            end
            if (ovf) ok = 0;
            if (op == 8'h56 && v > 100) ok = 0;
            if (op == 8'h41 && v > 90) ok = 0;
         end
         if (ok) begin
            err_m = 0;
            if (op == 8'h56)      vel_m = 32'(v);
            else if (op == 8'h41) ang_m = 32'(v);
            else                  ex.fire = 1;
         end else begin
            err_m = 1;
         end
      end
      ex.vel = vel_m;
      ex.ang = ang_m;
      ex.err = err_m;
      line_m.delete();
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 200) begin
         tick();
         k++;
      end
      if (busy) check("idle_timeout", busy, 0);
   endtask

   task automatic press_enter(input bit probe);
      exp_t ex;
      int   n;
      n               = line_m.size();
      input_character = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
      input_made      = 1'b1;
      tick();
      input_made      = 1'b0;
      model_commit(ex);
      ex.commit = cyc + n + 1;
      sb.push_back(ex);
      check("busy_after_enter", busy, 1);
      if (probe) begin
         input_character = 8'h51;
         input_made      = 1'b1;
         tick();
         input_made      = 1'b0;
      end
      wait_idle();
   endtask

   task automatic random_line();
      logic [7:0] lc [3];
      logic [7:0] junk [3];
      int sel;
      int nd;
      int r;
      lc   = '{8'h76, 8'h61, 8'h66};
      junk = '{8'h58, 8'h35, 8'h20};
      sel  = $urandom_range(0, 9);
      nd   = $urandom_range(0, 4);
      case (sel)
         0, 1, 2: send(8'h56);
         3, 4, 5: send(8'h41);
         6:       send(8'h46);
         7:       send(lc[$urandom_range(0, 2)]);
         8:       send(junk[$urandom_range(0, 2)]);
         default: ;
      endcase
      for (int i = 0; i < nd; i++) begin
         r = $urandom_range(0, 15);
         if (r == 0)      send(8'h08);
         else if (r == 1) send(8'(8'h20 + $urandom_range(0, 94)));
         else if (r == 2) send(8'h1B);
         else             send(8'(8'h30 + $urandom_range(0, 9)));
      end
      press_enter(0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #23;
      check("rst_line_content", line_content, '0);
      check("rst_line_ready", line_ready, 0);
      check("rst_velocity", velocity, 0);
      check("rst_angle", angle, 0);
      check("rst_fire", fire, 0);
      check("rst_cmd_error", cmd_error, 0);
      check("rst_busy", busy, 0);
      #4 reset = 1'b0;
      tick();

      send_str("V45");             press_enter(0);
      send_str("A9"); send(8'h08); send_str("30"); press_enter(0);
      send(8'h08); send(8'h08);    send_str("V7"); press_enter(0);
      press_enter(0);
      send_str("V100");            press_enter(0);
      send_str("A90");             press_enter(0);
      send_str("V101");            press_enter(0);
      send_str("A");               press_enter(0);
      send_str("X5");              press_enter(0);
      send_str("F1");              press_enter(0);
      send_str("V70000");          press_enter(0);
      send_str("A91");             press_enter(0);
      send_str("V0");              press_enter(0);

      // Fire, then a retrigger committed six cycles after the first commit.
      send_str("F");               press_enter(0);
      tick();
      send_str("F");               press_enter(0);
      repeat (15) tick();

      // Over-long line with a keystroke injected while busy.
      for (int i = 0; i < 40; i++) send(8'(8'h20 + $urandom_range(0, 94)));
      press_enter(1);

      send_str("V33");             press_enter(0);

      // Asynchronous reset in the middle of PARSE.
      send_str("V12");
      input_character = 8'h0D;
      input_made      = 1'b1;
      tick();
      input_made      = 1'b0;
      tick();
      #2 reset = 1'b1;
      #1;
      check("mid_rst_line_content", line_content, '0);
      check("mid_rst_line_ready", line_ready, 0);
      check("mid_rst_velocity", velocity, 0);
      check("mid_rst_angle", angle, 0);
      check("mid_rst_fire", fire, 0);
      check("mid_rst_cmd_error", cmd_error, 0);
      check("mid_rst_busy", busy, 0);
      line_m.delete();
      vel_m = 0;
      ang_m = 0;
      err_m = 0;
      #4 reset = 1'b0;
      tick();
      send_str("A15");             press_enter(0);

      send_str("v20");             press_enter(0);

      for (int i = 0; i < 60; i++) random_line();

      repeat (20) tick();
      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
